execute_mc: RTL and testbench



---
 rtl/execute_mc_pkg.sv | 42 ++++
 rtl/execute_mc_muldiv.sv | 113 +++++++++++
 rtl/execute_mc.sv | 180 ++++++++++++++++++
 tb/tb_execute_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mc_pkg.sv
// Shared opcode/funct encodings and mul/div FSM states for the execute stage.
package execute_mc_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_WIDTH-1:0] F_SLL   = 6'h00;
    localparam logic [FUNCT_WIDTH-1:0] F_SRL   = 6'h02;
    localparam logic [FUNCT_WIDTH-1:0] F_SRA   = 6'h03;
    localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = 6'h10;
    localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = 6'h12;
    localparam logic [FUNCT_WIDTH-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_WIDTH-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_WIDTH-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = 6'h1B;
    localparam logic [FUNCT_WIDTH-1:0] F_ADD   = 6'h20;
    localparam logic [FUNCT_WIDTH-1:0] F_SUB   = 6'h22;
    localparam logic [FUNCT_WIDTH-1:0] F_AND   = 6'h24;
    localparam logic [FUNCT_WIDTH-1:0] F_OR    = 6'h25;
    localparam logic [FUNCT_WIDTH-1:0] F_XOR   = 6'h26;
    localparam logic [FUNCT_WIDTH-1:0] F_NOR   = 6'h27;
    localparam logic [FUNCT_WIDTH-1:0] F_SLT   = 6'h2A;
    localparam logic [FUNCT_WIDTH-1:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/execute_mc_muldiv.sv
// Iterative multiply/divide engine: works on magnitudes, one shift-add or
// restoring-subtract step per cycle, then fixes signs when results are read.
module muldiv_iter
    import execute_mc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic         i_hold,
    input  logic         i_div,
    input  logic         i_signed,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    localparam int CW = $clog2(W) + 1;

    md_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_div;
    logic          r_neg_lo;
    logic          r_neg_hi;
    logic          r_dz;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_b;

    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W:0]     w_sum;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_prod;

    always_comb begin
        w_a_mag = (i_signed && i_a[W-1]) ? -i_a : i_a;
        w_b_mag = (i_signed && i_b[W-1]) ? -i_b : i_b;
        w_sum   = {1'b0, r_hi} + {1'b0, r_b};
        w_shift = {r_hi, r_lo[W-1]};
        // Partial remainder stays below the divisor, so bit W is the borrow.
        w_diff  = w_shift - {1'b0, r_b};
        w_prod  = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};
        if (r_div) begin
            o_lo = r_dz ? '1 : (r_neg_lo ? -r_lo : r_lo);
            o_hi = r_neg_hi ? -r_hi : r_hi;
        end else begin
            o_hi = w_prod[2*W-1:W];
            o_lo = w_prod[W-1:0];
        end
    end

    assign o_done = (r_state == MD_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (i_abort) begin
            r_state <= MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state  <= MD_BUSY;
                        r_cnt    <= CW'(W);
                        r_div    <= i_div;
                        r_neg_lo <= i_signed && (i_a[W-1] ^ i_b[W-1]);
                        r_neg_hi <= i_signed && i_a[W-1];
                        r_dz     <= i_div && (i_b == '0);
                        r_hi     <= '0;
                        r_lo     <= i_div ? w_a_mag : w_b_mag;
                        r_b      <= i_div ? w_b_mag : w_a_mag;
                    end
                end
                MD_BUSY: begin
                    if (r_div) begin
                        if (w_diff[W]) begin
                            r_hi <= w_shift[W-1:0];
                            r_lo <= {r_lo[W-2:0], 1'b0};
                        end else begin
                            r_hi <= w_diff[W-1:0];
                            r_lo <= {r_lo[W-2:0], 1'b1};
                        end
                    end else if (r_lo[0]) begin
                        {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
                    end else begin
                        {r_hi, r_lo} <= {1'b0, r_hi, r_lo[W-1:1]};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= MD_DONE;
                end
                MD_DONE: begin
                    if (!i_hold) r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_mc.sv
// Registered multi-cycle execute stage: single-cycle ALU/branch/JAL plus an
// iterative mul/div unit with HI/LO, busy interlock and stall/flush handling.
module execute_mc
    import execute_mc_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int JUMP_WIDTH = 26
) (
    input  logic                    es_clk,
    input  logic                    es_rst,
    input  logic                    es_i_ce,
    input  logic                    es_i_stall,
    input  logic                    es_i_flush,
    input  logic                    es_i_alu_src,
    input  logic                    es_i_jal,
    input  logic [JUMP_WIDTH-1:0]   es_i_jal_addr,
    input  logic [PC_WIDTH-1:0]     es_i_pc,
    input  logic [IMM_WIDTH-1:0]    es_i_imm,
    input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
    input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
    input  logic [DWIDTH-1:0]       es_i_data_rs,
    input  logic [DWIDTH-1:0]       es_i_data_rt,
    output logic [DWIDTH-1:0]       es_o_alu_value,
    output logic [PC_WIDTH-1:0]     es_o_alu_pc,
    output logic [OPCODE_WIDTH-1:0] es_o_opcode,
    output logic                    es_o_ce,
    output logic                    es_o_change_pc,
    output logic                    es_o_stall
);

    logic [1:0]              r_rst_sync;
    logic [DWIDTH-1:0]       r_hi;
    logic [DWIDTH-1:0]       r_lo;

    logic                    w_rst_n;
    logic [DWIDTH-1:0]       w_ext_imm;
    logic [DWIDTH-1:0]       w_opb;
    logic [PC_WIDTH-1:0]     w_pc4;
    logic [PC_WIDTH-1:0]     w_br;
    logic [4:0]              w_shamt;
    logic [DWIDTH-1:0]       w_value;
    logic [PC_WIDTH-1:0]     w_pc;
    logic                    w_change;
    logic                    w_redirect;
    logic                    w_is_md;
    logic                    w_md_div;
    logic                    w_md_signed;
    logic                    w_accept;
    logic                    w_md_done;
    logic [DWIDTH-1:0]       w_md_hi;
    logic [DWIDTH-1:0]       w_md_lo;

    // Reset asserts asynchronously but releases two clocks later, in sync.
    always_ff @(posedge es_clk or negedge es_rst) begin
        if (!es_rst) r_rst_sync <= '0;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_accept = es_i_ce && !es_o_stall && !es_i_stall && !es_i_flush;

    always_comb begin
        w_ext_imm = (es_i_alu_op == OP_ANDI || es_i_alu_op == OP_ORI)
                    ? DWIDTH'(es_i_imm) : DWIDTH'($signed(es_i_imm));
        w_opb       = es_i_alu_src ? w_ext_imm : es_i_data_rt;
        w_pc4       = es_i_pc + PC_WIDTH'(4);
        w_br        = w_pc4 + (PC_WIDTH'($signed(es_i_imm)) << 2);
        w_shamt     = es_i_imm[10:6];
        w_value     = '0;
        w_pc        = w_pc4;
        w_change    = 1'b0;
        w_redirect  = 1'b0;
        w_is_md     = 1'b0;
        w_md_div    = 1'b0;
        w_md_signed = 1'b0;
        if (es_i_jal) begin
            w_value    = DWIDTH'(w_pc4);
            w_pc       = {w_pc4[PC_WIDTH-1:JUMP_WIDTH+2], es_i_jal_addr, 2'b00};
            w_change   = 1'b1;
            w_redirect = 1'b1;
        end else begin
            case (es_i_alu_op)
                OP_RTYPE: begin
                    case (es_i_alu_funct)
                        F_ADD:   w_value = es_i_data_rs + w_opb;
                        F_SUB:   w_value = es_i_data_rs - w_opb;
                        F_AND:   w_value = es_i_data_rs & w_opb;
                        F_OR:    w_value = es_i_data_rs | w_opb;
                        F_XOR:   w_value = es_i_data_rs ^ w_opb;
                        F_NOR:   w_value = ~(es_i_data_rs | w_opb);
                        F_SLT:   w_value = DWIDTH'($signed(es_i_data_rs) < $signed(w_opb));
                        F_SLTU:  w_value = DWIDTH'(es_i_data_rs < w_opb);
                        F_SLL:   w_value = es_i_data_rt << w_shamt;
                        F_SRL:   w_value = es_i_data_rt >> w_shamt;
                        F_SRA:   w_value = DWIDTH'($signed(es_i_data_rt) >>> w_shamt);
                        F_MFHI:  w_value = r_hi;
                        F_MFLO:  w_value = r_lo;
                        F_MULT:  begin w_is_md = 1'b1; w_md_signed = 1'b1; end
                        F_MULTU: w_is_md = 1'b1;
                        F_DIV:   begin w_is_md = 1'b1; w_md_div = 1'b1; w_md_signed = 1'b1; end
                        F_DIVU:  begin w_is_md = 1'b1; w_md_div = 1'b1; end
                        default: w_value = '0;
                    endcase
                end
                OP_ADDI, OP_LW, OP_SW: w_value = es_i_data_rs + w_opb;
                OP_ANDI: w_value = es_i_data_rs & w_opb;
                OP_ORI:  w_value = es_i_data_rs | w_opb;
                OP_SLTI: w_value = DWIDTH'($signed(es_i_data_rs) < $signed(w_opb));
                OP_LUI:  w_value = DWIDTH'({es_i_imm, {IMM_WIDTH{1'b0}}});
                OP_BEQ: begin
                    w_change   = (es_i_data_rs == es_i_data_rt);
                    w_pc       = w_br;
                    w_redirect = 1'b1;
                end
                OP_BNE: begin
                    w_change   = (es_i_data_rs != es_i_data_rt);
                    w_pc       = w_br;
                    w_redirect = 1'b1;
                end
                default: w_value = '0;
            endcase
        end
    end

    muldiv_iter #(.W(DWIDTH)) u_muldiv (
        .clk      (es_clk),
        .rst_n    (w_rst_n),
        .i_start  (w_accept && w_is_md),
        .i_abort  (es_i_flush),
        .i_hold   (es_i_stall),
        .i_div    (w_md_div),
        .i_signed (w_md_signed),
        .i_a      (es_i_data_rs),
        .i_b      (es_i_data_rt),
        .o_done   (w_md_done),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    always_ff @(posedge es_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            es_o_alu_value <= '0;
            es_o_alu_pc    <= '0;
            es_o_opcode    <= '0;
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
            es_o_stall     <= 1'b0;
            r_hi           <= '0;
            r_lo           <= '0;
        end else if (es_i_flush) begin
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
            es_o_stall     <= 1'b0;
        end else if (!es_i_stall) begin
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
            if (w_md_done) begin
                r_hi           <= w_md_hi;
                r_lo           <= w_md_lo;
                es_o_alu_value <= w_md_lo;
                es_o_opcode    <= OP_RTYPE;
                es_o_ce        <= 1'b1;
                es_o_stall     <= 1'b0;
            end else if (w_accept) begin
                if (w_is_md) begin
                    es_o_stall <= 1'b1;
                end else begin
                    es_o_alu_value <= w_value;
                    es_o_opcode    <= es_i_alu_op;
                    es_o_change_pc <= w_change;
                    es_o_ce        <= 1'b1;
                    if (w_redirect) es_o_alu_pc <= w_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: ALU, branches, JAL, mul/div, stall, flush, reset.
module tb_execute_mc;
    import execute_mc_pkg::*;

    logic                    es_clk = 1'b0;
    logic                    es_rst;
    logic                    es_i_ce;
    logic                    es_i_stall;
    logic                    es_i_flush;
    logic                    es_i_alu_src;
    logic                    es_i_jal;
    logic [25:0]             es_i_jal_addr;
    logic [31:0]             es_i_pc;
    logic [15:0]             es_i_imm;
    logic [OPCODE_WIDTH-1:0] es_i_alu_op;
    logic [FUNCT_WIDTH-1:0]  es_i_alu_funct;
    logic [31:0]             es_i_data_rs;
    logic [31:0]             es_i_data_rt;
    logic [31:0]             es_o_alu_value;
    logic [31:0]             es_o_alu_pc;
    logic [OPCODE_WIDTH-1:0] es_o_opcode;
    logic                    es_o_ce;
    logic                    es_o_change_pc;
    logic                    es_o_stall;

    int n_chk = 0;
    int n_err = 0;

    execute_mc #(.DWIDTH(32), .PC_WIDTH(32), .IMM_WIDTH(16), .JUMP_WIDTH(26)) dut (
        .es_clk         (es_clk),
        .es_rst         (es_rst),
        .es_i_ce        (es_i_ce),
        .es_i_stall     (es_i_stall),
        .es_i_flush     (es_i_flush),
        .es_i_alu_src   (es_i_alu_src),
        .es_i_jal       (es_i_jal),
        .es_i_jal_addr  (es_i_jal_addr),
        .es_i_pc        (es_i_pc),
        .es_i_imm       (es_i_imm),
        .es_i_alu_op    (es_i_alu_op),
        .es_i_alu_funct (es_i_alu_funct),
        .es_i_data_rs   (es_i_data_rs),
        .es_i_data_rt   (es_i_data_rt),
        .es_o_alu_value (es_o_alu_value),
        .es_o_alu_pc    (es_o_alu_pc),
        .es_o_opcode    (es_o_opcode),
        .es_o_ce        (es_o_ce),
        .es_o_change_pc (es_o_change_pc),
        .es_o_stall     (es_o_stall)
    );

    always #5 es_clk = ~es_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge es_clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm, input logic src,
                         input logic [31:0] pc, input logic jal, input logic [25:0] ja);
        es_i_alu_op    = op;
        es_i_alu_funct = fn;
        es_i_data_rs   = rs;
        es_i_data_rt   = rt;
        es_i_imm       = imm;
        es_i_alu_src   = src;
        es_i_pc        = pc;
        es_i_jal       = jal;
        es_i_jal_addr  = ja;
        es_i_ce        = 1'b1;
        tick();
        es_i_ce        = 1'b0;
        es_i_jal       = 1'b0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
        issue(OP_RTYPE, fn, rs, rt, 16'h0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    task automatic itype(input logic [5:0] op, input logic [31:0] rs, input logic [15:0] imm);
        issue(op, 6'h0, rs, 32'h0, imm, 1'b1, 32'h0, 1'b0, 26'h0);
    endtask

    task automatic wait_ce(input string tag);
        int k = 0;
        while (es_o_ce !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk(tag, es_o_ce, 1);
    endtask

    task automatic count_ce(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (es_o_ce) seen++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int seen;
        es_rst = 1'b0; es_i_ce = 1'b0; es_i_stall = 1'b0; es_i_flush = 1'b0;
        es_i_alu_src = 1'b0; es_i_jal = 1'b0; es_i_jal_addr = '0; es_i_pc = '0;
        es_i_imm = '0; es_i_alu_op = '0; es_i_alu_funct = '0;
        es_i_data_rs = '0; es_i_data_rt = '0;
        repeat (3) tick();
        chk("rst_value", es_o_alu_value, 0);
        chk("rst_pc", es_o_alu_pc, 0);
        chk("rst_ce", es_o_ce, 0);
        chk("rst_chg", es_o_change_pc, 0);
        chk("rst_stall", es_o_stall, 0);
        chk("rst_opcode", es_o_opcode, 0);
        es_rst = 1'b1;
        repeat (3) tick();

        rtype(F_OR, 32'd5, 32'd4);
        chk("or_value", es_o_alu_value, 5);
        chk("or_ce", es_o_ce, 1);
        chk("or_chg", es_o_change_pc, 0);
        chk("or_stall", es_o_stall, 0);
        tick();
        chk("idle_ce", es_o_ce, 0);
        chk("idle_hold", es_o_alu_value, 5);

        es_i_flush = 1'b1;
        rtype(F_ADD, 32'd1, 32'd1);
        es_i_flush = 1'b0;
        chk("flush_ce", es_o_ce, 0);
        chk("flush_hold", es_o_alu_value, 5);

        issue(OP_BEQ, 6'h0, 32'd5, 32'd5, 16'd10, 1'b0, 32'd10, 1'b0, 26'h0);
        chk("beq_t_chg", es_o_change_pc, 1);
        chk("beq_t_pc", es_o_alu_pc, 54);
        chk("beq_t_val", es_o_alu_value, 0);
        issue(OP_BEQ, 6'h0, 32'd5, 32'd4, 16'd10, 1'b0, 32'd10, 1'b0, 26'h0);
        chk("beq_nt_chg", es_o_change_pc, 0);
        chk("beq_nt_ce", es_o_ce, 1);
        issue(OP_BNE, 6'h0, 32'd5, 32'd4, 16'hFFFF, 1'b0, 32'd100, 1'b0, 26'h0);
        chk("bne_chg", es_o_change_pc, 1);
        chk("bne_pc", es_o_alu_pc, 100);

        itype(OP_ADDI, 32'd5, 16'hFFFF);
        chk("addi", es_o_alu_value, 4);
        itype(OP_ANDI, 32'hFFFF_FFFF, 16'h8001);
        chk("andi_zext", es_o_alu_value, 32'h0000_8001);
        itype(OP_LUI, 32'h0, 16'h1234);
        chk("lui", es_o_alu_value, 32'h1234_0000);
        itype(OP_LW, 32'h100, 16'hFFF0);
        chk("lw_addr", es_o_alu_value, 32'h0F0);
        rtype(F_SLT, 32'hFFFF_FFFF, 32'd1);
        chk("slt", es_o_alu_value, 1);
        rtype(F_SLTU, 32'hFFFF_FFFF, 32'd1);
        chk("sltu", es_o_alu_value, 0);
        rtype(F_SUB, 32'd3, 32'd5);
        chk("sub_wrap", es_o_alu_value, 32'hFFFF_FFFE);
        issue(OP_RTYPE, F_SRA, 32'h0, 32'h8000_0000, 16'h0100, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("sra", es_o_alu_value, 32'hF800_0000);
        issue(6'h03, 6'h0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h100, 1'b1, 26'h123);
        chk("jal_val", es_o_alu_value, 32'h104);
        chk("jal_pc", es_o_alu_pc, 32'h48C);
        chk("jal_chg", es_o_change_pc, 1);
        tick();
        chk("jal_pulse", es_o_change_pc, 0);
        issue(6'h3F, 6'h0, 32'd9, 32'd9, 16'h0, 1'b0, 32'h0, 1'b0, 26'h0);
        chk("unk_ce", es_o_ce, 1);
        chk("unk_val", es_o_alu_value, 0);

        rtype(F_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_acc_stall", es_o_stall, 1);
        chk("mult_acc_ce", es_o_ce, 0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("mult_busy_stall", es_o_stall, 1);
            chk("mult_busy_ce", es_o_ce, 0);
        end
        tick();
        chk("mult_ce", es_o_ce, 1);
        chk("mult_lo", es_o_alu_value, 32'hFFFF_FFEB);
        chk("mult_stall_drop", es_o_stall, 0);
        tick();
        chk("mult_ce_pulse", es_o_ce, 0);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("mult_mfhi", es_o_alu_value, 32'hFFFF_FFFF);
        rtype(F_MFLO, 32'h0, 32'h0);
        chk("mult_mflo", es_o_alu_value, 32'hFFFF_FFEB);

        rtype(F_DIVU, 32'd7, 32'd0);
        wait_ce("divu0_ce");
        chk("divu0_lo", es_o_alu_value, 32'hFFFF_FFFF);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("divu0_hi", es_o_alu_value, 7);

        rtype(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_ce("div_ce");
        chk("div_lo", es_o_alu_value, 32'hFFFF_FFFD);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("div_hi", es_o_alu_value, 32'hFFFF_FFFF);

        rtype(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ce("divmin_ce");
        chk("divmin_lo", es_o_alu_value, 32'h8000_0000);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("divmin_hi", es_o_alu_value, 0);

        rtype(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_ce("div2_ce");
        rtype(F_DIV, 32'd100, 32'd7);
        repeat (4) tick();
        es_i_flush = 1'b1;
        tick();
        es_i_flush = 1'b0;
        chk("abort_stall", es_o_stall, 0);
        chk("abort_ce", es_o_ce, 0);
        count_ce(40, seen);
        chk("abort_no_ce", seen, 0);
        rtype(F_MFLO, 32'h0, 32'h0);
        chk("abort_mflo", es_o_alu_value, 32'hFFFF_FFFD);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("abort_mfhi", es_o_alu_value, 32'hFFFF_FFFF);

        rtype(F_MULTU, 32'd6, 32'd7);
        repeat (32) tick();
        es_i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_hold_ce", es_o_ce, 0);
            chk("done_hold_stall", es_o_stall, 1);
        end
        es_i_stall = 1'b0;
        tick();
        chk("done_rel_ce", es_o_ce, 1);
        chk("done_rel_val", es_o_alu_value, 42);
        chk("done_rel_stall", es_o_stall, 0);
        count_ce(5, seen);
        chk("done_once", seen, 0);
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("multu_hi", es_o_alu_value, 0);

        rtype(F_MULT, 32'd5, 32'd5);
        repeat (10) tick();
        #2;
        es_rst = 1'b0;
        #1;
        chk("midrst_val", es_o_alu_value, 0);
        chk("midrst_pc", es_o_alu_pc, 0);
        chk("midrst_stall", es_o_stall, 0);
        chk("midrst_ce", es_o_ce, 0);
        chk("midrst_chg", es_o_change_pc, 0);
        chk("midrst_op", es_o_opcode, 0);
        tick();
        es_rst = 1'b1;
        repeat (3) tick();
        rtype(F_MFHI, 32'h0, 32'h0);
        chk("midrst_hi", es_o_alu_value, 0);
        rtype(F_MFLO, 32'h0, 32'h0);
        chk("midrst_lo", es_o_alu_value, 0);
        count_ce(40, seen);
        chk("midrst_no_ce", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
